// File: rtl/detector_pkg.sv
// Shared types and constants for the 01[0*]1 sequence detector with BCD match counter.
//   state_e   : detector FSM states
//   SEG_*     : active-high seven-segment patterns, bit order {g,f,e,d,c,b,a}
//   BCD_MAX   : largest legal BCD digit
//   bcd_seg() : BCD digit to active-high segments; non-BCD codes map to blank
package detector_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S0   = 2'd1,
    S01  = 2'd2,
    S01Z = 2'd3
  } state_e;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [6:0] bcd_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seq_detector_counter_if.sv
// Bus bundle for seq_detector_counter.
//   in_valid, in_bit, clear : stimulus side (master drives)
//   match, count_bcd, overflow, seg : detector/counter/display results (slave drives)
interface seq_detector_counter_if #(
  parameter int unsigned NUM_DIGITS = 2
);

  logic                    in_valid;
  logic                    in_bit;
  logic                    clear;
  logic                    match;
  logic [4*NUM_DIGITS-1:0] count_bcd;
  logic                    overflow;
  logic [7*NUM_DIGITS-1:0] seg;

  modport master (
    output in_valid, in_bit, clear,
    input  match, count_bcd, overflow, seg
  );

  modport slave (
    input  in_valid, in_bit, clear,
    output match, count_bcd, overflow, seg
  );

endinterface

// File: rtl/bcd_to_7seg.sv
// One seven-segment digit decoder.
//   bcd        : 4-bit BCD digit
//   active_low : 1 inverts the pattern for common-anode displays
//   blank      : 1 forces all segments off
//   seg        : segments {g,f,e,d,c,b,a}
module bcd_to_7seg
  import detector_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       active_low,
  input  logic       blank,
  output logic [6:0] seg
);

  logic [6:0] seg_hi;

  always_comb begin
    seg_hi = blank ? SEG_BLANK : bcd_seg(bcd);
    seg    = active_low ? ~seg_hi : seg_hi;
  end

endmodule

// File: rtl/seq_detector_counter.sv
// Detects 01[0*]1 on a qualified serial stream, counts matches in an N-digit BCD counter
// and drives one seven-segment digit per counter digit.
//   clk_50MHz : system clock
//   rst_n     : asynchronous active-low reset
//   bus       : slave side of seq_detector_counter_if
//               in_valid/in_bit : qualified serial input
//               clear           : synchronous clear of count and overflow
//               match           : Mealy match pulse
//               count_bcd       : registered BCD count, digit 0 in [3:0]
//               overflow        : sticky, set when count passes all-9s
//               seg             : per-digit segments, digit 0 in [6:0]
module seq_detector_counter
  import detector_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 2,
  parameter bit          OVERLAP        = 1'b1,
  parameter bit          WRAP           = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          LZ_BLANK       = 1'b0
) (
  input logic                   clk_50MHz,
  input logic                   rst_n,
  seq_detector_counter_if.slave bus
);

  state_e state_q, state_d;
  logic   match;

  logic [NUM_DIGITS-1:0][3:0] count_q, count_d, count_inc;
  logic                       overflow_q, overflow_d;
  logic                       all_nines;
  logic                       carry;

  logic [NUM_DIGITS-1:0]      digit_blank;
  logic                       zero_above;
  logic [NUM_DIGITS-1:0][6:0] seg_w;

  // Detector FSM
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    match   = 1'b0;
    if (bus.in_valid) begin
      unique case (state_q)
        IDLE: state_d = bus.in_bit ? IDLE : S0;
        S0:   state_d = bus.in_bit ? S01 : S0;
        S01: begin
          if (bus.in_bit) begin
            match   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = S01Z;
          end
        end
        S01Z: begin
          if (bus.in_bit) begin
            match = 1'b1;
            // The closing '1' already forms the "01" prefix of the next match.
            state_d = OVERLAP ? S01 : IDLE;
          end else begin
            state_d = S01Z;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Decimal increment with carry ripple; all-9s rolls naturally to 0.
  always_comb begin
    all_nines = 1'b1;
    carry     = 1'b1;
    count_inc = count_q;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (count_q[i] != BCD_MAX) all_nines = 1'b0;
      if (carry) begin
        if (count_q[i] >= BCD_MAX) begin
          count_inc[i] = 4'd0;
        end else begin
          count_inc[i] = count_q[i] + 4'd1;
          carry        = 1'b0;
        end
      end
    end
  end

  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    if (bus.clear) begin
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (match) begin
      if (all_nines) begin
        overflow_d = 1'b1;
        count_d    = WRAP ? count_inc : count_q;
      end else begin
        count_d = count_inc;
      end
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Digit k>0 blanks only when it and every digit above it are zero.
  always_comb begin
    zero_above  = 1'b1;
    digit_blank = '0;
    for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
      zero_above     = zero_above & (count_q[i] == 4'd0);
      digit_blank[i] = LZ_BLANK & zero_above;
    end
  end

  for (genvar g = 0; g < int'(NUM_DIGITS); g++) begin : gen_digit
    bcd_to_7seg u_dec (
      .bcd        (count_q[g]),
      .active_low (SEG_ACTIVE_LOW),
      .blank      (digit_blank[g]),
      .seg        (seg_w[g])
    );
  end

  assign bus.match     = match;
  assign bus.count_bcd = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.seg       = seg_w;

endmodule

// File: tb/tb_seq_detector_counter.sv
// Two instances share stimulus:
//   dut_a : OVERLAP=1, WRAP=1, LZ_BLANK=0
//   dut_b : OVERLAP=0, WRAP=0, LZ_BLANK=1
module tb_seq_detector_counter;

  logic clk_50MHz = 1'b0;
  logic rst_n     = 1'b0;
  logic in_valid  = 1'b0;
  logic in_bit    = 1'b0;
  logic clear     = 1'b0;

  always #10 clk_50MHz = ~clk_50MHz;

  seq_detector_counter_if #(.NUM_DIGITS(2)) bus_a ();
  seq_detector_counter_if #(.NUM_DIGITS(2)) bus_b ();

  assign bus_a.in_valid = in_valid;
  assign bus_a.in_bit   = in_bit;
  assign bus_a.clear    = clear;
  assign bus_b.in_valid = in_valid;
  assign bus_b.in_bit   = in_bit;
  assign bus_b.clear    = clear;

  seq_detector_counter #(
    .NUM_DIGITS(2), .OVERLAP(1'b1), .WRAP(1'b1), .SEG_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b0)
  ) dut_a (
    .clk_50MHz (clk_50MHz),
    .rst_n     (rst_n),
    .bus       (bus_a.slave)
  );

  seq_detector_counter #(
    .NUM_DIGITS(2), .OVERLAP(1'b0), .WRAP(1'b0), .SEG_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b1)
  ) dut_b (
    .clk_50MHz (clk_50MHz),
    .rst_n     (rst_n),
    .bus       (bus_b.slave)
  );

  typedef struct packed {
    logic v;
    logic b;
    logic ma;
    logic mb;
  } vec_t;

  vec_t tbl [19];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_state(input string tag, input logic [7:0] ca, input logic oa,
                             input logic [13:0] sa, input logic [7:0] cb, input logic ob,
                             input logic [13:0] sb);
    check({tag, " count_a"}, 32'(bus_a.count_bcd), 32'(ca));
    check({tag, " ovf_a"},   32'(bus_a.overflow),  32'(oa));
    check({tag, " seg_a"},   32'(bus_a.seg),       32'(sa));
    check({tag, " count_b"}, 32'(bus_b.count_bcd), 32'(cb));
    check({tag, " ovf_b"},   32'(bus_b.overflow),  32'(ob));
    check({tag, " seg_b"},   32'(bus_b.seg),       32'(sb));
  endtask

  // Drive one cycle at the falling edge, check the Mealy match mid-cycle, return after rise.
  task automatic drive(input logic v, input logic b, input logic c,
                       input logic ema, input logic emb);
    @(negedge clk_50MHz);
    in_valid = v;
    in_bit   = b;
    clear    = c;
    #2;
    check("match_a", 32'(bus_a.match), 32'(ema));
    check("match_b", 32'(bus_b.match), 32'(emb));
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_50MHz);
    in_valid = 1'b0;
    in_bit   = 1'b0;
    clear    = 1'b0;
    rst_n    = 1'b0;
    #3;
    check_state("reset", 8'h00, 1'b0, {7'h40, 7'h40}, 8'h00, 1'b0, {7'h7F, 7'h40});
    #4;
    rst_n = 1'b1;
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) drive(tbl[i].v, tbl[i].b, 1'b0, tbl[i].ma, tbl[i].mb);
  endtask

  // Pattern 0,1,1 yields one match in both instances and returns them to IDLE.
  task automatic gen_match(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    end
  endtask

  initial begin
    // {valid, bit, match_a, match_b}
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 1'b1, 1'b1, 1'b1};

    // 0,1,1
    do_reset();
    run_range(0, 2);
    check_state("t1", 8'h01, 1'b0, {7'h40, 7'h79}, 8'h01, 1'b0, {7'h7F, 7'h79});

    // 0,1,0,1,0,1: overlap gives two matches, non-overlap one
    do_reset();
    run_range(3, 8);
    check_state("t2", 8'h02, 1'b0, {7'h40, 7'h24}, 8'h01, 1'b0, {7'h7F, 7'h79});

    // idle cycles with in_bit toggling inside the zero run
    do_reset();
    run_range(9, 18);
    check_state("t3", 8'h01, 1'b0, {7'h40, 7'h79}, 8'h01, 1'b0, {7'h7F, 7'h79});

    // wrap vs saturate at all-9s
    do_reset();
    gen_match(99);
    check_state("t4_99", 8'h99, 1'b0, {7'h10, 7'h10}, 8'h99, 1'b0, {7'h10, 7'h10});
    gen_match(1);
    check_state("t4_100", 8'h00, 1'b1, {7'h40, 7'h40}, 8'h99, 1'b1, {7'h10, 7'h10});
    gen_match(1);
    check_state("t4_101", 8'h01, 1'b1, {7'h40, 7'h79}, 8'h99, 1'b1, {7'h10, 7'h10});
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_state("t4_clr", 8'h00, 1'b0, {7'h40, 7'h40}, 8'h00, 1'b0, {7'h7F, 7'h40});

    // clear wins over a simultaneous match, but match still pulses
    do_reset();
    gen_match(5);
    check_state("t5_05", 8'h05, 1'b0, {7'h40, 7'h12}, 8'h05, 1'b0, {7'h7F, 7'h12});
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check_state("t5_clr", 8'h00, 1'b0, {7'h40, 7'h40}, 8'h00, 1'b0, {7'h7F, 7'h40});
    gen_match(1);
    check_state("t5_after", 8'h01, 1'b0, {7'h40, 7'h79}, 8'h01, 1'b0, {7'h7F, 7'h79});

    // leading-zero blanking at 07, then asynchronous reset from S01Z
    do_reset();
    gen_match(7);
    check_state("t6_07", 8'h07, 1'b0, {7'h40, 7'h78}, 8'h07, 1'b0, {7'h7F, 7'h78});
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #4;
    rst_n = 1'b0;
    #2;
    check_state("t6_async", 8'h00, 1'b0, {7'h40, 7'h40}, 8'h00, 1'b0, {7'h7F, 7'h40});
    #2;
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_state("t6_post", 8'h00, 1'b0, {7'h40, 7'h40}, 8'h00, 1'b0, {7'h7F, 7'h40});

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seq_detector_counter.md
Name: seq_detector_counter

Overview:
Parametrised successor to the single-pattern 01[0*]1 detector. Detects 01[0*]1 on a qualified serial bit stream, with selectable overlapping or non-overlapping matching. Counts matches in an N-digit BCD counter with wrap or saturate mode. Drives N seven-segment digits directly, for board-level display of the match count.

Parameters:
NUM_DIGITS, 2, number of BCD digits in counter and display (1..6)
OVERLAP, 1, 1: the final '1' of a match that ended with 0+ may start the next match; 0: the FSM restarts after every match
WRAP, 1, 1: counter wraps from all-9s to 0; 0: counter saturates at all-9s
SEG_ACTIVE_LOW, 1, 1: segment outputs active-low (common anode); 0: active-high
LZ_BLANK, 0, 1: blank leading-zero digits; digit 0 is never blanked

Ports:
clk_50MHz  input  1  system clock, 50 MHz
rst_n  input  1  reset, asynchronous assert, active-low
in_valid  input  1  qualifies in_bit for this cycle
in_bit  input  1  serial data bit
clear  input  1  synchronous clear of count and overflow
match  output  1  Mealy match pulse, combinational from state and inputs
count_bcd  output  4*NUM_DIGITS  registered BCD count; digit 0 in bits [3:0]
overflow  output  1  sticky; set when count passes all-9s
seg  output  7*NUM_DIGITS  per-digit segments, {g,f,e,d,c,b,a}; digit 0 in bits [6:0]

Behaviour:
- Design uses one clock and one reset. Reset is asynchronous and active-low (rst_n).
- While rst_n is low: state = IDLE, count_bcd = 0, overflow = 0.
- While rst_n is low, seg on digit 0 shows "0" (7'h40 when active-low). Other digits show "0", or blank (7'h7F) when LZ_BLANK=1.
- FSM states: IDLE, S0 (seen 0), S01 (seen 01), S01Z (seen 01 followed by 0+).
- FSM advances only when in_valid=1. With in_valid=0, state holds, in_bit is ignored and match=0.
- Transitions:
  - IDLE: 0->S0, 1->IDLE.
  - S0: 0->S0, 1->S01.
  - S01: 0->S01Z, 1->match, then IDLE.
  - S01Z: 0->S01Z, 1->match, then S01 if OVERLAP=1, else IDLE.
- match = in_valid & in_bit & (state==S01 | state==S01Z). Zero latency (Mealy). It is asserted even when clear=1.
- count_bcd increments on the clock edge where match=1, so it reflects the match in the cycle after the match. Increment is decimal, with carry ripple across digits.
- At all-9s, when match=1:
  - WRAP=1: count becomes 0.
  - WRAP=0: count holds all-9s.
  - In both modes overflow is set to 1 and stays set.
- clear=1: count_bcd <= 0 and overflow <= 0 next edge. Clear has priority over a simultaneous match. The FSM is unaffected by clear.
- seg is combinational from count_bcd: no extra latency, and no glitch masking is required.
- Digit encoding, active-high: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; blank=00. Active-low is the bitwise inverse.
- With LZ_BLANK=1, digit k>0 is blank iff it and all digits above it are 0.
- Asserting rst_n low mid-stream aborts partial detection immediately, and count is lost.
- Non-BCD digit values are unreachable. The decoder still maps them to blank.

Decomposition:
- Package detector_pkg holds:
  - state enum: IDLE, S0, S01, S01Z
  - 7-bit segment constants for 0-9 and blank (active-high)
  - BCD_MAX = 4'd9
- One sub-module, bcd_to_7seg: 4-bit BCD in, ACTIVE_LOW and BLANK inputs, 7-bit segment out. It is instantiated NUM_DIGITS times in a generate loop.
- FSM and BCD counter stay in seq_detector_counter.

Test Plan:
1. Reset, then valid bits 0,1,1 -> match pulses on the third bit; count_bcd=8'h01 next cycle; seg[6:0]=7'h79.
2. OVERLAP=1, bits 0,1,0,1,0,1 -> match on bits 4 and 6; count_bcd=8'h02. OVERLAP=0, same stream -> match on bit 4 only; count_bcd=8'h01.
3. Bits 0,1,0,0,0,0,1 with in_valid dropped for 3 idle cycles mid-zeros, in_bit toggling during the idle cycles -> exactly one match on the final 1; match stays 0 on idle cycles.
4. NUM_DIGITS=2, WRAP=1, drive 100 matches -> count goes 8'h99 then 8'h00; overflow=1 and stays set. WRAP=0, same stimulus -> count holds 8'h99, overflow=1.
5. clear asserted in the same cycle as a match at count 8'h05 -> match=1 that cycle; count_bcd=8'h00 and overflow=0 next cycle.
6. LZ_BLANK=1, count 8'h07 -> seg[13:7]=7'h7F and seg[6:0]=7'h78. Pulse rst_n low asynchronously mid-pattern (state S01Z) -> outputs return to reset values without a clock edge; the next bit 1 gives no match.
